// File: rtl/data_mem_responder.sv
// Word-organised, byte-enabled data memory answering the mem_valid/mem_ready
// protocol with a fixed response latency; one request in flight at a time.
module data_mem_responder #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 1024,
  parameter int unsigned            LATENCY     = 2,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [3:0]            mem_byte_en,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_ready,
  output logic                  mem_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  inr_q, inr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_in_range;
  logic                  req_we, req_inr;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_be;
  logic                  write_en;

  assign offset        = mem_addr - BASE_ADDR;
  assign addr_in_range = (mem_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  // With LATENCY=1 the RESP-entry edge is the acceptance edge, so the live
  // request fields must be used there instead of the captured copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_we    = mem_we;
      req_inr   = addr_in_range;
      req_idx   = offset[IDX_W+1:2];
      req_wdata = mem_w_data;
      req_be    = mem_byte_en;
    end else begin
      req_we    = we_q;
      req_inr   = inr_q;
      req_idx   = idx_q;
      req_wdata = wdata_q;
      req_be    = be_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    inr_d   = inr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          we_d    = mem_we;
          idx_d   = offset[IDX_W+1:2];
          wdata_d = mem_w_data;
          be_d    = mem_byte_en;
          inr_d   = addr_in_range;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      err_d   = !req_inr;
      rdata_d = (!req_we && req_inr) ? mem_q[req_idx] : '0;
    end
  end

  assign write_en = (state_d == S_RESP) && req_we && req_inr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      inr_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      inr_q   <= inr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only the commit is suppressed by it.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_be[i]) mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign mem_r_data = rdata_q;
  assign mem_ready  = ready_q;
  assign mem_err    = err_q;

endmodule
